// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the PWM sample DAC output stage.
//   - state_e          : output-stage FSM states (IDLE, RAMP, RUN)
//   - SAMPLE_W/PWM_BITS: default sample and PWM resolutions
//   - MIDSCALE         : duty value that represents a zero-amplitude sample
//   - to_offset_duty() : two's complement sample -> offset-binary PWM duty
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int PWM_BITS   = 8;
    localparam int FIFO_DEPTH = 4;

    localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Flipping the sign bit turns two's complement into offset binary, so the
    // most negative sample maps to duty 0 and zero maps to midscale.
    function automatic logic [PWM_BITS-1:0] to_offset_duty(input logic [SAMPLE_W-1:0] sample);
        return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: PWM_BITS-1]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO with first-word-fall-through head for the sample path.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i : write request and data (ignored while full)
//   pop_i         : read request (ignored while empty)
//   head_o        : oldest entry, valid whenever empty_o is low
//   count_o       : occupancy, 0..DEPTH
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Occupancy next state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pwm_sample_dac.sv
// -----------------------------------------------------------------------------
// pwm_sample_dac
// Audio output stage: buffers signed PCM samples and plays one sample per PWM
// period (2**PWM_BITS clocks) as a 1-bit PWM waveform.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : run the PWM; low returns to IDLE (FIFO contents are kept)
//   s_valid    : sample offered
//   s_data     : signed sample
//   s_ready    : FIFO has room (no look-ahead on a same-cycle pop)
//   audio_out  : registered PWM output
//   underrun   : one-clock pulse at a RUN period boundary with an empty FIFO
//   duty       : duty currently in effect (debug)
//   fifo_count : FIFO occupancy (debug)
// Configuration:
//   PWM_DAC_SOFTRAMP_EN : when defined, enable first passes through RAMP, which
//   raises duty from 0 to midscale one step per period to avoid a start-up pop.
// Note: the sample-to-duty mapping comes from audio_pkg, so SAMPLE_W and
// PWM_BITS are expected to keep the package values.
// -----------------------------------------------------------------------------
module pwm_sample_dac
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int PWM_BITS   = audio_pkg::PWM_BITS,
    parameter int FIFO_DEPTH = audio_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          s_valid,
    input  logic [SAMPLE_W-1:0]           s_data,
    output logic                          s_ready,
    output logic                          audio_out,
    output logic                          underrun,
    output logic [PWM_BITS-1:0]           duty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

    state_e                state_q;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic                  audio_q;
    logic                  underrun_q;

    logic                  boundary_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [SAMPLE_W-1:0]   fifo_head_s;
    logic [PWM_BITS-1:0]   duty_step_s;

    assign boundary_s  = (pwm_cnt_q == CNT_MAX);
    assign s_ready     = !fifo_full_s;
    assign push_s      = s_valid && s_ready;
    // Pops only happen in RUN at a boundary, and not on the cycle enable drops.
    assign pop_s       = enable && (state_q == RUN) && boundary_s && !fifo_empty_s;
    assign duty_step_s = duty_q + PWM_BITS'(1);

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (s_data),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Output-stage FSM with PWM counter, duty register and registered compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pwm_cnt_q  <= {PWM_BITS{1'b0}};
            duty_q     <= MIDSCALE;
            audio_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                pwm_cnt_q <= {PWM_BITS{1'b0}};
                duty_q    <= MIDSCALE;
                audio_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        pwm_cnt_q <= {PWM_BITS{1'b0}};
                        audio_q   <= 1'b0;
`ifdef PWM_DAC_SOFTRAMP_EN
                        state_q   <= RAMP;
                        duty_q    <= {PWM_BITS{1'b0}};
`else
                        state_q   <= RUN;
                        duty_q    <= MIDSCALE;
`endif
                    end
`ifdef PWM_DAC_SOFTRAMP_EN
                    RAMP: begin
                        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
                        audio_q   <= (pwm_cnt_q < duty_q);
                        if (boundary_s) begin
                            duty_q <= duty_step_s;
                            // Popping begins at the boundary after midscale is reached.
                            if (duty_step_s == MIDSCALE) begin
                                state_q <= RUN;
                            end else begin
                                state_q <= RAMP;
                            end
                        end else begin
                            duty_q <= duty_q;
                        end
                    end
`endif
                    RUN: begin
                        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
                        audio_q   <= (pwm_cnt_q < duty_q);
                        // New duty lands at the boundary, so it is in effect from the next cnt=0.
                        if (boundary_s) begin
                            if (!fifo_empty_s) begin
                                duty_q <= to_offset_duty(fifo_head_s);
                            end else begin
                                duty_q     <= duty_q;
                                underrun_q <= 1'b1;
                            end
                        end else begin
                            duty_q <= duty_q;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        pwm_cnt_q <= {PWM_BITS{1'b0}};
                        duty_q    <= MIDSCALE;
                        audio_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign audio_out = audio_q;
    assign underrun  = underrun_q;
    assign duty      = duty_q;

endmodule

// File: tb/tb_pwm_sample_dac.sv
// -----------------------------------------------------------------------------
// tb_pwm_sample_dac
// Directed bench for pwm_sample_dac with hand-computed expectations.
// Inputs change just after the falling edge; outputs are sampled at the
// falling edge following each rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_sample_dac;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        audio_out;
    logic        underrun;
    logic [7:0]  duty;
    logic [2:0]  fifo_count;

    int n_checks;
    int n_fails;
    int highs;
    int unders;
    int total_unders;

    pwm_sample_dac dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .audio_out  (audio_out),
        .underrun   (underrun),
        .duty       (duty),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    // One PWM period (256 clocks), optionally pushing a sample on its first clock.
    task automatic run_period(input logic do_push, input logic [15:0] pdata,
                              output int hi, output int un);
        hi = 0;
        un = 0;
        for (int i = 0; i < 256; i++) begin
            if (do_push && i == 0) begin
                s_valid = 1'b1;
                s_data  = pdata;
            end
            tick();
            if (do_push && i == 0) begin
                s_valid = 1'b0;
            end
            hi += int'(audio_out);
            un += int'(underrun);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state and push while idle
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_audio", 32'(audio_out), 32'd0);
        check_eq("rst_duty", 32'(duty), 32'h80);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        push(16'h0000);
        check_eq("idle_push_count", 32'(fifo_count), 32'd1);
        total_unders = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_unders += int'(underrun) + int'(audio_out);
        end
        check_eq("idle_no_pop", 32'(fifo_count), 32'd1);
        check_eq("idle_quiet", 32'(total_unders), 32'd0);

`ifndef PWM_DAC_SOFTRAMP_EN
        // Direct start: midscale, then 0x7FFF, then 0x8000
        do_reset();
        push(16'h7FFF);
        push(16'h8000);
        check_eq("pre_count", 32'(fifo_count), 32'd2);
        enable = 1'b1;
        tick();
        check_eq("entry_duty", 32'(duty), 32'h80);
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("p1_highs", 32'(highs), 32'd128);
        check_eq("p1_duty_next", 32'(duty), 32'hFF);
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("p2_highs", 32'(highs), 32'd255);
        check_eq("p2_duty_next", 32'(duty), 32'h00);
        check_eq("p2_count", 32'(fifo_count), 32'd0);
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("p3_highs", 32'(highs), 32'd0);
        check_eq("p3_underrun", 32'(unders), 32'd1);
        check_eq("p3_duty_hold", 32'(duty), 32'h00);

        // Underrun repeats each boundary; refill loads at the next boundary
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("p4_underrun", 32'(unders), 32'd1);
        check_eq("p4_duty_hold", 32'(duty), 32'h00);
        run_period(1'b1, 16'h4000, highs, unders);
        check_eq("p5_underrun", 32'(unders), 32'd0);
        check_eq("p5_duty_next", 32'(duty), 32'hC0);
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("p6_highs", 32'(highs), 32'd192);
        check_eq("p6_underrun", 32'(unders), 32'd1);

        // Full FIFO: pop at boundary, held push accepted one clock later
        enable = 1'b0;
        tick();
        check_eq("dis_duty", 32'(duty), 32'h80);
        check_eq("dis_audio", 32'(audio_out), 32'd0);
        push(16'h1000);
        push(16'h2000);
        push(16'h3000);
        push(16'h4000);
        check_eq("full_count", 32'(fifo_count), 32'd4);
        check_eq("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'h5000;
        enable  = 1'b1;
        tick();
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("full_p_highs", 32'(highs), 32'd128);
        check_eq("full_pop_count", 32'(fifo_count), 32'd3);
        check_eq("full_pop_ready", 32'(s_ready), 32'd1);
        check_eq("full_pop_duty", 32'(duty), 32'h90);
        tick();
        check_eq("full_refill_count", 32'(fifo_count), 32'd4);
        s_valid = 1'b0;
        repeat (255) tick();
        check_eq("full_next_duty", 32'(duty), 32'hA0);
        check_eq("full_next_count", 32'(fifo_count), 32'd3);
`else
        // Soft ramp: duty climbs 0..0x80, no pops or underrun, then RUN
        do_reset();
        push(16'h7FFF);
        enable = 1'b1;
        tick();
        check_eq("ramp_start_duty", 32'(duty), 32'h00);
        total_unders = 0;
        for (int k = 0; k < 128; k++) begin
            run_period(1'b0, 16'h0000, highs, unders);
            total_unders += unders;
            check_eq("ramp_duty", 32'(duty), 32'(k + 1));
            check_eq("ramp_count", 32'(fifo_count), 32'd1);
        end
        check_eq("ramp_underrun", 32'(total_unders), 32'd0);
        run_period(1'b0, 16'h0000, highs, unders);
        check_eq("ramp_run_highs", 32'(highs), 32'd128);
        check_eq("ramp_first_pop", 32'(duty), 32'hFF);
        check_eq("ramp_pop_count", 32'(fifo_count), 32'd0);
        enable = 1'b0;
        tick();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
`endif

        // Reset mid-period with three samples buffered
        enable = 1'b0;
        tick();
        check_eq("pre_rst_count", 32'(fifo_count), 32'd3);
        enable = 1'b1;
        tick();
        repeat (50) tick();
`ifndef PWM_DAC_SOFTRAMP_EN
        check_eq("pre_rst_audio", 32'(audio_out), 32'd1);
`endif
        rst = 1'b1;
        #1;
        check_eq("async_rst_audio", 32'(audio_out), 32'd0);
        check_eq("async_rst_count", 32'(fifo_count), 32'd0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("post_rst_duty", 32'(duty), 32'h80);
        check_eq("post_rst_audio", 32'(audio_out), 32'd0);
        check_eq("post_rst_ready", 32'(s_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
